queue_drain: RTL and testbench
==============================

# queue_drain

Read-side controller for the circular FIFO `queue`. It issues pop requests, absorbs the queue's one-cycle registered pop latency in a 2-entry holding buffer, and presents entries downstream over a valid/ready handshake with no loss, duplication or reordering. It sits between a `queue` instance's pop port and the consuming pipeline stage.

## Interface
- DATA_WIDTH, 32, entry width in bits; must match the attached `queue`.
- CNT_WIDTH, 16, width of the delivered-entry counter.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- drainEn_IN  input  1  permits new pops when high.
- emptyFlag_IN  input  1  queue empty flag.
- data_IN  input  DATA_WIDTH  queue popped data.
- popValid_IN  input  1  queue popped-data valid.
- popReq_OUT  output  1  pop request to the queue (combinational).
- data_OUT  output  DATA_WIDTH  downstream data.
- valid_OUT  output  1  downstream data valid.
- ready_IN  input  1  downstream ready.
- inFlight_OUT  output  1  a pop was issued last cycle and its response is due this cycle.
- error_OUT  output  1  sticky protocol-error flag.
- delivered_OUT  output  CNT_WIDTH  count of completed downstream transfers.

## Operation
- State:
  - Holding buffer of 2 slots with 1-bit rdPtr/wrPtr and a 2-bit occ (0..2).
  - inFlight register.
  - error register.
  - delivered counter.
- accept = valid_OUT && ready_IN.
- popReq_OUT = drainEn_IN && !emptyFlag_IN && (occ + inFlight - accept) < 2.
  - The combinational path from ready_IN to popReq_OUT is intentional; it gives 1 entry/cycle steady-state throughput.
  - popReq_OUT is never asserted while emptyFlag_IN is high, so the queue bypass path is never exercised.
- inFlight is set to popReq_OUT every cycle.
- Capture:
  - If popValid_IN is high and inFlight is high, write data_IN to slot[wrPtr], increment wrPtr, and increment occ.
  - The credit rule guarantees occ < 2 at capture.
- Output:
  - valid_OUT = (occ != 0).
  - data_OUT = slot[rdPtr].
  - On accept, increment rdPtr, decrement occ, and increment delivered.
- Simultaneous capture and accept: occ is unchanged and both pointers advance.
- Protocol errors (error set sticky, cleared only by reset):
  - popValid_IN high while inFlight is low: data is dropped, no state change.
  - inFlight high while popValid_IN is low: the expected entry is lost, inFlight still clears, occ unchanged.
- drainEn_IN low:
  - Blocks only new pops.
  - An in-flight response is still captured.
  - Held entries still drain downstream.
- delivered wraps modulo 2^CNT_WIDTH.
- data_OUT holds its value while valid_OUT is high and ready_IN is low (valid/ready stability rule).

## Timing
- Reset (synchronous, active-high, takes effect at the clk edge where reset is high):
  - occ = 0, rdPtr = 0, wrPtr = 0.
  - inFlight = 0, so inFlight_OUT = 0.
  - error_OUT = 0.
  - delivered_OUT = 0.
  - valid_OUT = 0.
  - data_OUT = 0: slots clear to 0.
  - popReq_OUT is forced to 0 while reset is high.
- Reset mid-operation discards held and in-flight entries. Entries already popped from the queue are lost; this is accepted system behaviour.
- Pop-to-output latency:
  - popReq_OUT high in cycle N.
  - popValid_IN/data_IN in cycle N+1, captured at the end of N+1.
  - valid_OUT in cycle N+2.
- Throughput: 1 entry/cycle with ready_IN held high and the queue non-empty.
- Backpressure: with ready_IN low, at most 2 further entries are captured, then popReq_OUT stays low until an accept frees a slot.
  - popReq_OUT may reassert in the same cycle as that accept.
- Boundary cases:
  - occ = 2 with accept: pop allowed.
  - occ = 2 with no accept: no pop.
  - occ = 1, inFlight = 1, no accept: no pop.
  - Pointer wrap 1 to 0 is natural 1-bit overflow.

## Test plan
- Stream: reset, then push A=0x11, B=0x22, C=0x33 into the queue, ready_IN=1, drainEn_IN=1 -> popReq_OUT high for 3 consecutive cycles; valid_OUT high for 3 consecutive cycles with data_OUT A, B, C, starting 2 cycles after the first pop; delivered_OUT=3; error_OUT=0.
- Backpressure: queue holds 5 entries, ready_IN=0 -> exactly 2 pops, occ=2, valid_OUT=1 with data_OUT stable at the first entry; raise ready_IN -> remaining 3 entries follow in order, with no gaps after the first 2-cycle refill; delivered_OUT=5.
- Empty/disable:
  - emptyFlag_IN=1 for 10 cycles -> popReq_OUT=0 and valid_OUT=0 throughout.
  - Drop drainEn_IN in the same cycle as a pop -> the in-flight entry is still captured and delivered, and no further pops occur.
- Protocol errors:
  - Inject popValid_IN=1 with inFlight_OUT=0 -> error_OUT=1 next cycle, occ unchanged.
  - After reset, suppress popValid_IN following a pop -> error_OUT=1 and inFlight_OUT=0.
- Reset mid-stream with occ=2 and inFlight=1 -> next cycle all outputs are at reset values and popReq_OUT=0 while reset is high.
- Counter wrap: CNT_WIDTH=4, deliver 17 entries -> delivered_OUT=1.

Source files
------------

// File: rtl/queue_drain.sv
// queue_drain: read-side controller for the circular FIFO `queue`.
// Issues credit-limited pop requests, captures the one-cycle-late pop
// response into a 2-slot holding buffer and presents entries downstream
// over valid/ready without loss, duplication or reordering.
module queue_drain #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drainEn_IN,
    input  logic                  emptyFlag_IN,
    input  logic [DATA_WIDTH-1:0] data_IN,
    input  logic                  popValid_IN,
    output logic                  popReq_OUT,
    output logic [DATA_WIDTH-1:0] data_OUT,
    output logic                  valid_OUT,
    input  logic                  ready_IN,
    output logic                  inFlight_OUT,
    output logic                  error_OUT,
    output logic [CNT_WIDTH-1:0]  delivered_OUT
);

    // Holding buffer and bookkeeping
    logic [DATA_WIDTH-1:0] r_slot [2];
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [1:0]            r_occ;
    logic                  r_inFlight;
    logic                  r_error;
    logic [CNT_WIDTH-1:0]  r_delivered;

    logic                  w_accept;
    logic                  w_capture;
    logic                  w_protoErr;
    logic [2:0]            w_committed;
    logic                  w_pop;

    // Handshake, capture and credit decode; ready_IN reaches popReq_OUT
    // combinationally so a freed slot can be refilled in the same cycle.
    always_comb begin
        w_accept    = (r_occ != 2'd0) && ready_IN;
        w_capture   = popValid_IN && r_inFlight;
        w_protoErr  = popValid_IN ^ r_inFlight;
        w_committed = {1'b0, r_occ} + {2'b00, r_inFlight} - {2'b00, w_accept};
        w_pop       = !reset && drainEn_IN && !emptyFlag_IN && (w_committed < 3'd2);
    end

    // Read/write pointers and occupancy; simultaneous capture and accept
    // advance both pointers and leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_occ   <= '0;
        end else begin
            if (w_capture) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_accept) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_capture, w_accept})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Slot storage: captured pop data is written at the write pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_slot[i] <= '0;
            end
        end else if (w_capture) begin
            r_slot[r_wrPtr] <= data_IN;
        end
    end

    // In-flight marker: a pop issued this cycle expects a response next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inFlight <= 1'b0;
        end else begin
            r_inFlight <= w_pop;
        end
    end

    // Sticky protocol error: unexpected response or missing response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_protoErr) begin
            r_error <= 1'b1;
        end
    end

    // Completed-transfer counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delivered <= '0;
        end else if (w_accept) begin
            r_delivered <= r_delivered + 1'b1;
        end
    end

    assign popReq_OUT    = w_pop;
    assign valid_OUT     = (r_occ != 2'd0);
    assign data_OUT      = r_slot[r_rdPtr];
    assign inFlight_OUT  = r_inFlight;
    assign error_OUT     = r_error;
    assign delivered_OUT = r_delivered;

endmodule

// File: tb/tb_queue_drain.sv
// tb_queue_drain: queue_drain driven by a behavioural FIFO with one-cycle
// pop latency, checked against a queue-level reference model.
module tb_queue_drain;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, drainEn_IN, emptyFlag_IN, popValid_IN, ready_IN;
    logic [DW-1:0] data_IN;
    logic          popReq_OUT, valid_OUT, inFlight_OUT, error_OUT;
    logic [DW-1:0] data_OUT;
    logic [15:0]   delivered_OUT;
    logic          popReq4, valid4, inFlight4, error4;
    logic [DW-1:0] data4;
    logic [3:0]    delivered4;

    queue_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .drainEn_IN(drainEn_IN), .emptyFlag_IN(emptyFlag_IN),
        .data_IN(data_IN), .popValid_IN(popValid_IN), .popReq_OUT(popReq_OUT),
        .data_OUT(data_OUT), .valid_OUT(valid_OUT), .ready_IN(ready_IN),
        .inFlight_OUT(inFlight_OUT), .error_OUT(error_OUT), .delivered_OUT(delivered_OUT)
    );

    queue_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .drainEn_IN(drainEn_IN), .emptyFlag_IN(emptyFlag_IN),
        .data_IN(data_IN), .popValid_IN(popValid_IN), .popReq_OUT(popReq4),
        .data_OUT(data4), .valid_OUT(valid4), .ready_IN(ready_IN),
        .inFlight_OUT(inFlight4), .error_OUT(error4), .delivered_OUT(delivered4)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Behavioural source FIFO
    logic [DW-1:0] qm[$];
    logic          resp_pending = 1'b0;
    logic [DW-1:0] resp_data = '0;

    // Reference model: entries popped but not yet delivered, plus flags
    logic [DW-1:0] m_held[$];
    logic          m_inflight = 1'b0;
    logic          m_err = 1'b0;
    int unsigned   m_deliv = 0;
    logic          m_known = 1'b0;

    // Stimulus controls
    logic c_rst, c_drain, c_ready, c_force_empty, c_inject, c_suppress;
    int unsigned n_pops = 0;

    // Per-cycle logs for directed pattern checks
    logic          log_pop[$];
    logic          log_valid[$];
    logic [DW-1:0] log_data[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against model, advance model
    task automatic step();
        logic          exp_valid, acc, exp_pop, pop_now, cap;
        logic [DW-1:0] exp_data;
        int            committed;
        reset        = c_rst;
        drainEn_IN   = c_drain;
        ready_IN     = c_ready;
        emptyFlag_IN = c_force_empty || (qm.size() == 0);
        if (resp_pending && !c_suppress) begin
            popValid_IN = 1'b1;
            data_IN     = resp_data;
        end else if (c_inject && !resp_pending) begin
            popValid_IN = 1'b1;
            data_IN     = $urandom;
        end else begin
            popValid_IN = 1'b0;
            data_IN     = $urandom;
        end
        #4;
        exp_valid = (m_held.size() != 0);
        exp_data  = '0;
        if (exp_valid) exp_data = m_held[0];
        acc       = exp_valid && c_ready;
        committed = int'(m_held.size()) + int'(m_inflight) - int'(acc);
        exp_pop   = !c_rst && c_drain && !emptyFlag_IN && (committed < 2);
        if (m_known) begin
            chk("popReq",    64'(popReq_OUT),    64'(exp_pop));
            chk("valid",     64'(valid_OUT),     64'(exp_valid));
            chk("inFlight",  64'(inFlight_OUT),  64'(m_inflight));
            chk("error",     64'(error_OUT),     64'(m_err));
            chk("delivered", 64'(delivered_OUT), 64'(m_deliv & 32'hFFFF));
            chk("deliv4",    64'(delivered4),    64'(m_deliv & 32'hF));
            if (exp_valid) chk("data", 64'(data_OUT), 64'(exp_data));
        end
        log_pop.push_back(popReq_OUT);
        log_valid.push_back(valid_OUT);
        log_data.push_back(data_OUT);
        if (popReq_OUT) n_pops++;
        pop_now = popReq_OUT && (qm.size() != 0);
        cap     = popValid_IN && m_inflight;
        @(posedge clk);
        #1;
        if (c_rst) begin
            m_held.delete();
            m_inflight = 1'b0;
            m_err      = 1'b0;
            m_deliv    = 0;
            m_known    = 1'b1;
        end else begin
            if (acc) begin
                void'(m_held.pop_front());
                m_deliv++;
            end
            if (cap) m_held.push_back(data_IN);
            if (popValid_IN != m_inflight) m_err = 1'b1;
            m_inflight = exp_pop;
        end
        if (pop_now) begin
            resp_data    = qm.pop_front();
            resp_pending = 1'b1;
        end else begin
            resp_pending = 1'b0;
        end
    endtask

    task automatic do_reset();
        c_rst = 1'b1;
        step();
        chk("rst_valid",    64'(valid_OUT),     64'd0);
        chk("rst_data",     64'(data_OUT),      64'd0);
        chk("rst_inflight", 64'(inFlight_OUT),  64'd0);
        chk("rst_error",    64'(error_OUT),     64'd0);
        chk("rst_deliv",    64'(delivered_OUT), 64'd0);
        chk("rst_popreq",   64'(popReq_OUT),    64'd0);
        c_rst = 1'b0;
    endtask

    task automatic clear_logs();
        log_pop.delete();
        log_valid.delete();
        log_data.delete();
    endtask

    task automatic run_until_deliv(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (m_deliv < target && n < budget) begin
            step();
            n++;
        end
        chk("deliv_reached", 64'(m_deliv >= target), 64'd1);
    endtask

    initial begin
        logic [7:0]  pv, vv;
        int unsigned p0, d0, vc;
        c_rst = 1'b1; c_drain = 1'b0; c_ready = 1'b0;
        c_force_empty = 1'b0; c_inject = 1'b0; c_suppress = 1'b0;
        reset = 1'b1; drainEn_IN = 1'b0; emptyFlag_IN = 1'b1;
        popValid_IN = 1'b0; ready_IN = 1'b0; data_IN = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Stream of three entries at full throughput
        qm = '{32'h11, 32'h22, 32'h33};
        c_drain = 1'b1; c_ready = 1'b1;
        clear_logs();
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            pv[i] = log_pop[i];
            vv[i] = log_valid[i];
        end
        chk("stream_pops",  64'(pv), 64'h07);
        chk("stream_valid", 64'(vv), 64'h1C);
        chk("stream_A", 64'(log_data[2]), 64'h11);
        chk("stream_B", 64'(log_data[3]), 64'h22);
        chk("stream_C", 64'(log_data[4]), 64'h33);
        chk("stream_deliv", 64'(delivered_OUT), 64'd3);
        chk("stream_err",   64'(error_OUT), 64'd0);

        // Backpressure: two captures then no pops until a slot frees
        do_reset();
        for (int i = 0; i < 5; i++) qm.push_back(32'hA0 + 32'(i));
        c_ready = 1'b0;
        clear_logs();
        repeat (6) step();
        for (int i = 0; i < 6; i++) begin
            pv[i] = log_pop[i];
            vv[i] = log_valid[i];
        end
        chk("bp_pops",  64'(pv[5:0]), 64'h03);
        chk("bp_valid", 64'(vv[5:0]), 64'h3C);
        for (int i = 2; i < 6; i++) chk("bp_hold", 64'(log_data[i]), 64'hA0);
        c_ready = 1'b1;
        clear_logs();
        repeat (5) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_order_v", 64'(log_valid[i]), 64'd1);
            chk("bp_order_d", 64'(log_data[i]), 64'hA0 + 64'(i));
        end
        repeat (2) step();
        chk("bp_deliv", 64'(delivered_OUT), 64'd5);

        // Empty flag forced for 10 cycles with entries waiting
        qm = '{32'hC1, 32'hC2, 32'hC3};
        c_force_empty = 1'b1;
        p0 = n_pops;
        clear_logs();
        repeat (10) step();
        vc = 0;
        foreach (log_valid[i]) if (log_valid[i]) vc++;
        chk("empty_pops",  64'(n_pops - p0), 64'd0);
        chk("empty_valid", 64'(vc), 64'd0);
        c_force_empty = 1'b0;

        // Drain disabled right after a pop: the in-flight entry still lands
        p0 = n_pops;
        d0 = m_deliv;
        step();
        c_drain = 1'b0;
        clear_logs();
        repeat (5) step();
        chk("dis_pops",  64'(n_pops - p0), 64'd1);
        chk("dis_deliv", 64'(delivered_OUT), 64'(d0 + 1));
        chk("dis_data",  64'(log_data[1]), 64'hC1);
        qm.delete();

        // Spurious pop response
        do_reset();
        c_inject = 1'b1;
        step();
        c_inject = 1'b0;
        chk("spur_err",   64'(error_OUT), 64'd1);
        chk("spur_valid", 64'(valid_OUT), 64'd0);
        step();

        // Missing pop response
        do_reset();
        qm = '{32'h55};
        c_drain = 1'b1;
        step();
        c_suppress = 1'b1;
        step();
        c_suppress = 1'b0;
        chk("miss_err",      64'(error_OUT), 64'd1);
        chk("miss_inflight", 64'(inFlight_OUT), 64'd0);
        chk("miss_valid",    64'(valid_OUT), 64'd0);
        step();

        // Reset mid-stream with a full buffer and a pop in flight
        do_reset();
        for (int i = 0; i < 6; i++) qm.push_back(32'hD0 + 32'(i));
        c_ready = 1'b0;
        repeat (3) step();
        chk("mid_full_valid", 64'(valid_OUT), 64'd1);
        c_ready = 1'b1;
        step();
        chk("mid_inflight", 64'(inFlight_OUT), 64'd1);
        do_reset();
        qm.delete();

        // Counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) qm.push_back($urandom);
        run_until_deliv(17, 60);
        chk("wrap4",   64'(delivered4), 64'd1);
        chk("wrap16",  64'(delivered_OUT), 64'd17);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            c_drain       = ($urandom % 10) != 0;
            c_ready       = ($urandom % 4) != 0;
            c_force_empty = ($urandom % 20) == 0;
            c_inject      = ($urandom % 250) == 0;
            c_suppress    = ($urandom % 250) == 0;
            c_rst         = ($urandom % 400) == 0;
            if (($urandom % 3) != 0 && qm.size() < 8) qm.push_back($urandom);
            step();
        end
        c_rst = 1'b0; c_inject = 1'b0; c_suppress = 1'b0; c_force_empty = 1'b0;
        c_drain = 1'b1; c_ready = 1'b1;
        d0 = m_deliv + 32'(m_held.size()) + 32'(m_inflight) + 32'(qm.size());
        run_until_deliv(d0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
